npu_writeback_serializer: RTL and testbench

Downstream write-back stage for the layer-1/2 memory-read/compute block. It captures the 16 parallel 8-bit PE results (u0..u15) on each `start_write_back` pulse and serializes them, one byte per cycle, into the result RAM through `wr_en` / `ram_store_addr` / `ram_wdata`. A one-deep pending slot lets the next result vector arrive while the current one drains. `stop_write_back` closes the layer and rewinds the store address.

---
 rtl/npu_writeback_serializer.sv | 198 +++++++++++++++++++
 tb/tb_npu_writeback_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_writeback_serializer.sv
// npu_writeback_serializer: captures LANES x DATA_W result vectors and streams them into the result RAM, one lane per cycle.
// Optional build macro WB_RELU_EN: negative (MSB set) lanes are stored as zero at capture.
module npu_writeback_serializer #(
    parameter int                DATA_W    = 8,
    parameter int                LANES     = 16,
    parameter int                ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_write_back,
    input  logic                    stop_write_back,
    input  logic [LANES*DATA_W-1:0] lanes_in,
    input  logic [4:0]              lane_count,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       ram_store_addr,
    output logic [DATA_W-1:0]       ram_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int IDX_W = $clog2(LANES);
    localparam int CNT_W = 5;
    localparam int VEC_W = LANES * DATA_W;

    typedef enum logic [1:0] {IDLE, WRITE, CLOSE} state_t;

    state_t             state_q,          state_d;
    logic [VEC_W-1:0]   active_q,         active_d;
    logic [CNT_W-1:0]   act_cnt_q,        act_cnt_d;
    logic [VEC_W-1:0]   pend_q,           pend_d;
    logic [CNT_W-1:0]   pend_cnt_q,       pend_cnt_d;
    logic               pend_vld_q,       pend_vld_d;
    logic [IDX_W-1:0]   lane_idx_q,       lane_idx_d;
    logic [ADDR_W-1:0]  addr_q,           addr_d;
    logic               stop_q,           stop_d;
    logic               wr_en_q,          wr_en_d;
    logic [ADDR_W-1:0]  ram_store_addr_q, ram_store_addr_d;
    logic [DATA_W-1:0]  ram_wdata_q,      ram_wdata_d;
    logic               busy_q,           busy_d;
    logic               done_q,           done_d;
    logic               overflow_q,       overflow_d;

    logic [VEC_W-1:0]   captured;
    logic [CNT_W-1:0]   cnt_in;
    logic               last_lane;

    function automatic logic [VEC_W-1:0] shape_lanes(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0] r;
        r = v;
`ifdef WB_RELU_EN
        for (int k = 0; k < LANES; k++) begin
            if (v[k*DATA_W + DATA_W - 1]) r[k*DATA_W +: DATA_W] = '0;
        end
`endif
        return r;
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first, so no path through the case can infer a latch.
        state_d          = state_q;
        active_d         = active_q;
        act_cnt_d        = act_cnt_q;
        pend_d           = pend_q;
        pend_cnt_d       = pend_cnt_q;
        pend_vld_d       = pend_vld_q;
        lane_idx_d       = lane_idx_q;
        addr_d           = addr_q;
        stop_d           = stop_q;
        wr_en_d          = 1'b0;
        ram_wdata_d      = ram_wdata_q;
        done_d           = 1'b0;
        overflow_d       = overflow_q;

        captured  = shape_lanes(lanes_in);
        cnt_in    = (lane_count == '0) ? CNT_W'(LANES) : lane_count;
        last_lane = ({1'b0, lane_idx_q} == (act_cnt_q - CNT_W'(1)));

        unique case (state_q)
            IDLE: begin
                if (start_write_back) begin
                    active_d   = captured;
                    act_cnt_d  = cnt_in;
                    lane_idx_d = '0;
                    stop_d     = stop_q | stop_write_back;
                    state_d    = WRITE;
                end else if (stop_write_back || stop_q) begin
                    state_d = CLOSE;
                end
            end

            WRITE: begin
                wr_en_d     = 1'b1;
                ram_wdata_d = active_q[lane_idx_q*DATA_W +: DATA_W];
                addr_d      = addr_q + ADDR_W'(1);
                lane_idx_d  = lane_idx_q + IDX_W'(1);
                if (stop_write_back) stop_d = 1'b1;

                if (last_lane) begin
                    // Next burst starts on the following cycle: pending first, else a start arriving right now.
                    lane_idx_d = '0;
                    if (pend_vld_q) begin
                        active_d   = pend_q;
                        act_cnt_d  = pend_cnt_q;
                        pend_vld_d = 1'b0;
                        if (start_write_back) begin
                            pend_d     = captured;
                            pend_cnt_d = cnt_in;
                            pend_vld_d = 1'b1;
                        end
                    end else if (start_write_back) begin
                        active_d  = captured;
                        act_cnt_d = cnt_in;
                    end else if (stop_q || stop_write_back) begin
                        state_d = CLOSE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start_write_back) begin
                    if (!pend_vld_q) begin
                        pend_d     = captured;
                        pend_cnt_d = cnt_in;
                        pend_vld_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end

            CLOSE: begin
                done_d = 1'b1;
                addr_d = BASE_ADDR;
                stop_d = stop_write_back;
                if (start_write_back) begin
                    active_d   = captured;
                    act_cnt_d  = cnt_in;
                    lane_idx_d = '0;
                    state_d    = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // The address port shows the counter one cycle late, so it is the write address while wr_en is high.
        ram_store_addr_d = addr_q;
        busy_d           = (state_d != IDLE) || pend_vld_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the lane buffers are plain registers, not RAM, so they are cleared with everything else.
            state_q          <= IDLE;
            active_q         <= '0;
            act_cnt_q        <= '0;
            pend_q           <= '0;
            pend_cnt_q       <= '0;
            pend_vld_q       <= 1'b0;
            lane_idx_q       <= '0;
            addr_q           <= BASE_ADDR;
            stop_q           <= 1'b0;
            wr_en_q          <= 1'b0;
            ram_store_addr_q <= BASE_ADDR;
            ram_wdata_q      <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling the pre-edge values.
            state_q          <= state_d;
            active_q         <= active_d;
            act_cnt_q        <= act_cnt_d;
            pend_q           <= pend_d;
            pend_cnt_q       <= pend_cnt_d;
            pend_vld_q       <= pend_vld_d;
            lane_idx_q       <= lane_idx_d;
            addr_q           <= addr_d;
            stop_q           <= stop_d;
            wr_en_q          <= wr_en_d;
            ram_store_addr_q <= ram_store_addr_d;
            ram_wdata_q      <= ram_wdata_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            overflow_q       <= overflow_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign ram_store_addr = ram_store_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_npu_writeback_serializer.sv
// Self-checking bench for npu_writeback_serializer: random lane data against a burst-level reference model.
// Build with +define+WB_RELU_EN to exercise the clamp; the model follows the same macro.
module tb_npu_writeback_serializer;

    localparam int          DATA_W = 8;
    localparam int          LANES  = 16;
    localparam int          ADDR_W = 14;
    localparam logic [13:0] BASE   = 14'd0;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_write_back = 1'b0;
    logic         stop_write_back = 1'b0;
    logic [127:0] lanes_in = '0;
    logic [4:0]   lane_count = '0;
    logic         wr_en;
    logic [13:0]  ram_store_addr;
    logic [7:0]   ram_wdata;
    logic         busy;
    logic         done;
    logic         overflow;

    npu_writeback_serializer #(
        .DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset),
        .start_write_back(start_write_back), .stop_write_back(stop_write_back),
        .lanes_in(lanes_in), .lane_count(lane_count),
        .wr_en(wr_en), .ram_store_addr(ram_store_addr), .ram_wdata(ram_wdata),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_done[$];
    int          m_last_s = -1000;
    int          m_last_e = -1000;
    logic [13:0] m_addr = BASE;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_writes = 0;
    logic [13:0] last_wr_addr = '0;

    function automatic logic [7:0] lane_model(input logic [7:0] b);
`ifdef WB_RELU_EN
        if ($signed(b) < 0) return 8'h00;
`endif
        return b;
    endfunction

    function automatic logic [127:0] rand_lanes();
        logic [127:0] v;
        for (int k = 0; k < LANES; k++) v[k*8 +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    // A start is accepted unless an accepted burst is still waiting to begin beyond the next cycle.
    task automatic model_start(input int n, input logic [127:0] v, input logic [4:0] c);
        int cnt;
        int s;
        wr_t w;
        cnt = (c == 5'd0) ? LANES : int'(c);
        if (m_last_s > n + 1) return;
        s = (n + 1 > m_last_e + 1) ? n + 1 : m_last_e + 1;
        for (int i = 0; i < cnt; i++) begin
            w.cyc  = s + i;
            w.addr = m_addr;
            w.data = lane_model(v[i*8 +: 8]);
            exp_wr.push_back(w);
            m_addr = m_addr + 14'd1;
        end
        m_last_s = s;
        m_last_e = s + cnt - 1;
    endtask

    task automatic model_stop(input int n, input bit with_start);
        if (!with_start && m_last_e < n) exp_done.push_back(n + 1);
        else                             exp_done.push_back(m_last_e + 1);
        m_addr = BASE;
    endtask

    task automatic model_reset();
        exp_wr.delete();
        exp_done.delete();
        m_last_s = -1000;
        m_last_e = -1000;
        m_addr   = BASE;
    endtask

    task automatic drive(input bit s, input bit p, input logic [127:0] v, input logic [4:0] c);
        int n;
        n = cyc + 1;
        start_write_back = s;
        stop_write_back  = p;
        lanes_in         = v;
        lane_count       = c;
        if (s) model_start(n, v, c);
        if (p) model_stop(n, s);
        @(posedge clk);
        #1;
        start_write_back = 1'b0;
        stop_write_back  = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0 || busy !== 1'b0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (exp_wr.size() != 0 || exp_done.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain: writes_left=%0d done_left=%0d busy=%b, required 0/0/0",
                     name, exp_wr.size(), exp_done.size(), busy);
            exp_wr.delete();
            exp_done.delete();
        end
    endtask

    wr_t mon_w;
    int  mon_d;
    always @(negedge clk) begin
        if (reset) begin
            if (wr_en === 1'b1) begin
                n_writes++;
                last_wr_addr = ram_store_addr;
                n_cmp++;
                if (exp_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h cyc=%0d, required no write",
                             ram_store_addr, ram_wdata, cyc);
                end else begin
                    mon_w = exp_wr.pop_front();
                    if (cyc != mon_w.cyc || ram_store_addr !== mon_w.addr || ram_wdata !== mon_w.data) begin
                        n_err++;
                        $display("FAIL write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                                 cyc, ram_store_addr, ram_wdata, mon_w.cyc, mon_w.addr, mon_w.data);
                    end
                end
            end
            if (done === 1'b1) begin
                n_cmp++;
                if (exp_done.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got done at cyc=%0d, required none", cyc);
                end else begin
                    mon_d = exp_done.pop_front();
                    if (cyc != mon_d) begin
                        n_err++;
                        $display("FAIL done_cycle: got cyc=%0d, required cyc=%0d", cyc, mon_d);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        #12;
        n_cmp += 6;
        if (wr_en !== 1'b0)          begin n_err++; $display("FAIL rst_wr_en: got %b, required 0", wr_en); end
        if (ram_store_addr !== BASE) begin n_err++; $display("FAIL rst_addr: got %0d, required %0d", ram_store_addr, BASE); end
        if (ram_wdata !== 8'h00)     begin n_err++; $display("FAIL rst_wdata: got %h, required 00", ram_wdata); end
        if (busy !== 1'b0)           begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (done !== 1'b0)           begin n_err++; $display("FAIL rst_done: got %b, required 0", done); end
        if (overflow !== 1'b0)       begin n_err++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [127:0] v;
        int w0;
        for (int k = 0; k < LANES; k++) v[k*8 +: 8] = 8'(k + 1);
        w0 = n_writes;
        drive(1'b1, 1'b0, v, 5'd16);
        wait_drain("single", 60);
        n_cmp += 2;
        if (n_writes - w0 != 16) begin n_err++; $display("FAIL single_count: got %0d writes, required 16", n_writes - w0); end
        if (busy !== 1'b0)       begin n_err++; $display("FAIL single_busy: got %b, required 0", busy); end
        // lane_count of zero means a full burst
        w0 = n_writes;
        drive(1'b1, 1'b0, rand_lanes(), 5'd0);
        wait_drain("count_zero", 60);
        n_cmp++;
        if (n_writes - w0 != 16) begin n_err++; $display("FAIL count_zero: got %0d writes, required 16", n_writes - w0); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, rand_lanes(), 5'd16);
        idle(2);
        drive(1'b1, 1'b0, rand_lanes(), 5'd4);
        wait_drain("b2b", 80);
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow: got %b, required 0", overflow); end
        // random short bursts, each started on the last lane of the previous one
        for (int r = 0; r < 4; r++) begin
            int c;
            c = $urandom_range(1, 16);
            drive(1'b1, 1'b0, rand_lanes(), 5'(c));
            idle(c - 1);
        end
        wait_drain("b2b_rand", 80);
    endtask

    task automatic test_overflow();
        int w0;
        w0 = n_writes;
        drive(1'b1, 1'b0, rand_lanes(), 5'd16);
        drive(1'b1, 1'b0, rand_lanes(), 5'd16);
        drive(1'b1, 1'b0, rand_lanes(), 5'd16);
        wait_drain("overflow", 100);
        n_cmp += 2;
        if (n_writes - w0 != 32) begin n_err++; $display("FAIL ovf_count: got %0d writes, required 32", n_writes - w0); end
        if (overflow !== 1'b1)   begin n_err++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
        idle(10);
        n_cmp++;
        if (overflow !== 1'b1)   begin n_err++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    endtask

    task automatic test_start_stop();
        int k;
        drive(1'b1, 1'b1, rand_lanes(), 5'd8);
        k = 0;
        while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        @(negedge clk);
        n_cmp++;
        if (ram_store_addr !== BASE) begin n_err++; $display("FAIL stop_rewind: got addr=%0d, required %0d", ram_store_addr, BASE); end
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, rand_lanes(), 5'($urandom_range(1, 16)));
        wait_drain("after_stop", 60);
        drive(1'b0, 1'b1, '0, 5'd0);
        wait_drain("idle_stop", 20);
        // stop armed while a pending burst waits: done only after both drain
        drive(1'b1, 1'b0, rand_lanes(), 5'd16);
        drive(1'b1, 1'b0, rand_lanes(), 5'd5);
        idle(2);
        drive(1'b0, 1'b1, '0, 5'd0);
        wait_drain("deferred_stop", 80);
        n_cmp++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL stop_ovf_sticky: got %b, required 1", overflow); end
    endtask

    task automatic test_wrap();
        for (int b = 0; b < 1023; b++) begin
            drive(1'b1, 1'b0, rand_lanes(), 5'd16);
            idle(15);
        end
        drive(1'b1, 1'b0, rand_lanes(), 5'd12);
        idle(11);
        drive(1'b1, 1'b0, rand_lanes(), 5'd8);
        wait_drain("wrap", 100);
        n_cmp++;
        if (last_wr_addr !== 14'd3) begin n_err++; $display("FAIL wrap_last_addr: got %0d, required 3", last_wr_addr); end
        drive(1'b0, 1'b1, '0, 5'd0);
        wait_drain("wrap_stop", 20);
    endtask

    task automatic test_relu();
        logic [127:0] v;
        v = rand_lanes();
        v[7:0]  = 8'h80;
        v[15:8] = 8'h7F;
        v[23:16] = 8'hFF;
        v[31:24] = 8'h00;
        drive(1'b1, 1'b0, v, 5'd16);
        wait_drain("relu", 60);
    endtask

    task automatic test_reset_mid_burst();
        int w0;
        drive(1'b1, 1'b0, rand_lanes(), 5'd16);
        idle(4);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp += 4;
        if (wr_en !== 1'b0)          begin n_err++; $display("FAIL mid_rst_wr_en: got %b, required 0", wr_en); end
        if (busy !== 1'b0)           begin n_err++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        if (overflow !== 1'b0)       begin n_err++; $display("FAIL mid_rst_overflow: got %b, required 0", overflow); end
        if (ram_store_addr !== BASE) begin n_err++; $display("FAIL mid_rst_addr: got %0d, required %0d", ram_store_addr, BASE); end
        w0 = n_writes;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(25);
        n_cmp++;
        if (n_writes != w0) begin n_err++; $display("FAIL mid_rst_no_writes: got %0d writes, required 0", n_writes - w0); end
        drive(1'b1, 1'b0, rand_lanes(), 5'd3);
        wait_drain("post_reset", 40);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_start_stop();
        test_wrap();
        test_relu();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
